// File: rtl/util_pktarb_pkg.sv
// Shared types and helpers for the packet arbitration multiplexer.
package util_pktarb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GAP  = 2'd1,
      XFER = 2'd2
   } arb_state_e;

   localparam int ALG_FIXED = 0;
   localparam int ALG_RR    = 1;
   localparam int ALG_WRR   = 2;

   // Number of bits needed to hold the given non-negative value (0 for 0).
   function automatic int BIT_WIDTH(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((value >> i) != 0) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/util_pktarb_pick.sv
// Masked priority picker: one-hot winner among requesters, searching upward
// from the pointer with wrap (round robin) or from channel 0 (fixed priority).
module util_pktarb_pick import util_pktarb_pkg::*; #(
   parameter int CHANNEL_QTY = 6,
   parameter int PTR_WIDTH   = 3
) (
   input  logic [CHANNEL_QTY-1:0] req_i,
   input  logic [PTR_WIDTH-1:0]   ptr_i,
   input  logic [1:0]             alg_i,
   output logic [CHANNEL_QTY-1:0] win_o
);

   logic found;
   int   startIdx;

   // Two passes: first channels at or above the start point, then the wrapped part below it.
   always_comb begin
      win_o    = '0;
      found    = 1'b0;
      startIdx = ((alg_i == 2'(ALG_RR)) || (alg_i == 2'(ALG_WRR))) ? int'(ptr_i) : 0;
      for (int c = 0; c < CHANNEL_QTY; c++) begin
         if (!found && req_i[c] && (c >= startIdx)) begin
            win_o[c] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int c = 0; c < CHANNEL_QTY; c++) begin
         if (!found && req_i[c] && (c < startIdx)) begin
            win_o[c] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/util_pktarb_mux.sv
// Packet multiplexer with multilevel arbitration, packet-held grants, optional
// weighted bursts, switch gap and stall watchdog, valid/ready on both sides.
module util_pktarb_mux import util_pktarb_pkg::*; #(
   parameter int DATA_WIDTH      = 64,
   parameter int EMPT_WIDTH      = BIT_WIDTH(DATA_WIDTH/8-1),
   parameter int CHANNEL_QTY     = 6,
   parameter int ARBIT_LEVEL     = 2,
   parameter int ARBIT_ALGORITHM = 1,
   parameter int WEIGHT_WIDTH    = 4,
   parameter int MUX_SW_DELAY    = 2,
   parameter int TIMEOUT_CYCLES  = 0,
   parameter int INDX_WIDTH      = 10,
   localparam int EW             = (EMPT_WIDTH > 1) ? EMPT_WIDTH : 1
) (
   input  logic                    clk_arbit,
   input  logic                    rst_n,
   input  logic [CHANNEL_QTY-1:0]  din_valid,
   output logic [CHANNEL_QTY-1:0]  din_ready,
   input  logic [CHANNEL_QTY-1:0]  din_sop,
   input  logic [CHANNEL_QTY-1:0]  din_eop,
   input  logic [DATA_WIDTH-1:0]   din_data [CHANNEL_QTY],
   input  logic [EW-1:0]           din_empty [CHANNEL_QTY],
   input  logic [ARBIT_LEVEL-1:0]  arbit_request [CHANNEL_QTY],
   input  logic [WEIGHT_WIDTH-1:0] arbit_weight [CHANNEL_QTY],
   output logic [CHANNEL_QTY-1:0]  arbit_grant,
   output logic [INDX_WIDTH-1:0]   arbit_index,
   output logic                    arbit_abort,
   output logic                    dout_valid,
   input  logic                    dout_ready,
   output logic                    dout_sop,
   output logic                    dout_eop,
   output logic [DATA_WIDTH-1:0]   dout_data,
   output logic [EW-1:0]           dout_empty
);

   localparam int PW = (CHANNEL_QTY > 1) ? $clog2(CHANNEL_QTY) : 1;
   localparam int GW = (BIT_WIDTH(MUX_SW_DELAY) > 0) ? BIT_WIDTH(MUX_SW_DELAY) : 1;
   localparam int TW = (BIT_WIDTH(TIMEOUT_CYCLES) > 0) ? BIT_WIDTH(TIMEOUT_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((MUX_SW_DELAY > 0) ? MUX_SW_DELAY - 1 : 0);
   localparam logic [TW-1:0] WD_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [WEIGHT_WIDTH-1:0] CREDIT_ONE = WEIGHT_WIDTH'(1);
   localparam logic [1:0] ALG = 2'(ARBIT_ALGORITHM);

   arb_state_e              state_q;
   logic [CHANNEL_QTY-1:0]  grant_q;
   logic [INDX_WIDTH-1:0]   index_q;
   logic                    abort_q;
   logic [PW-1:0]           ptr_q;
   logic [WEIGHT_WIDTH-1:0] credit_q;
   logic [GW-1:0]           gapCnt_q;
   logic [TW-1:0]           wdCnt_q;

   logic [CHANNEL_QTY-1:0]  levelVec;
   logic [CHANNEL_QTY-1:0]  levelReq;
   logic [CHANNEL_QTY-1:0]  winner;
   logic [WEIGHT_WIDTH-1:0] winWeight;
   logic [WEIGHT_WIDTH-1:0] credit_d;
   logic [PW-1:0]           ptr_d;
   logic                    selValid;
   logic                    selSop;
   logic                    selEop;
   logic [DATA_WIDTH-1:0]   selData;
   logic [EW-1:0]           selEmpty;
   logic                    grantReqAny;
   logic                    xferActive;
   logic                    accept;

   // Keep only the requests of the highest level that has any requester.
   always_comb begin
      levelReq = '0;
      levelVec = '0;
      for (int n = 0; n < ARBIT_LEVEL; n++) begin
         levelVec = '0;
         for (int c = 0; c < CHANNEL_QTY; c++) begin
            levelVec[c] = arbit_request[c][n];
         end
         if (|levelVec) begin
            levelReq = levelVec;
         end
      end
   end

   util_pktarb_pick #(
      .CHANNEL_QTY (CHANNEL_QTY),
      .PTR_WIDTH   (PW)
   ) u_pick (
      .req_i (levelReq),
      .ptr_i (ptr_q),
      .alg_i (ALG),
      .win_o (winner)
   );

   // Gather the granted channel's stream, its request state and the pointer past it,
   // plus the burst credit the new winner would start with.
   always_comb begin
      selValid    = 1'b0;
      selSop      = 1'b0;
      selEop      = 1'b0;
      selData     = '0;
      selEmpty    = '0;
      grantReqAny = 1'b0;
      ptr_d       = '0;
      winWeight   = '0;
      for (int c = 0; c < CHANNEL_QTY; c++) begin
         if (grant_q[c]) begin
            selValid    = din_valid[c];
            selSop      = din_sop[c];
            selEop      = din_eop[c];
            selData     = din_data[c];
            selEmpty    = din_empty[c];
            grantReqAny = |arbit_request[c];
            ptr_d       = (c == CHANNEL_QTY - 1) ? '0 : PW'(c + 1);
         end
         if (winner[c]) begin
            winWeight = arbit_weight[c];
         end
      end
      credit_d = (winWeight == '0) ? CREDIT_ONE : winWeight;
   end

   assign xferActive  = (state_q == XFER);
   assign din_ready   = xferActive ? (grant_q & {CHANNEL_QTY{dout_ready}}) : '0;
   assign dout_valid  = xferActive & selValid;
   assign dout_sop    = dout_valid & selSop;
   assign dout_eop    = dout_valid & selEop;
   assign dout_data   = xferActive ? selData : '0;
   assign dout_empty  = xferActive ? selEmpty : '0;
   assign accept      = dout_valid & dout_ready;
   assign arbit_grant = grant_q;
   assign arbit_index = index_q;
   assign arbit_abort = abort_q;

   // Arbitration FSM: grant in IDLE, wait out the switch gap, hold grant until eop or watchdog.
   always_ff @(posedge clk_arbit or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         index_q  <= '0;
         abort_q  <= 1'b0;
         ptr_q    <= '0;
         credit_q <= '0;
         gapCnt_q <= '0;
         wdCnt_q  <= '0;
      end else begin
         abort_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|winner) begin
                  grant_q  <= winner;
                  credit_q <= credit_d;
                  gapCnt_q <= '0;
                  wdCnt_q  <= '0;
                  index_q  <= '0;
                  state_q  <= (MUX_SW_DELAY > 0) ? GAP : XFER;
               end
            end
            GAP: begin
               if (!grantReqAny) begin
                  grant_q <= '0;
                  state_q <= IDLE;
               end else if (gapCnt_q == GAP_LAST) begin
                  index_q <= '0;
                  wdCnt_q <= '0;
                  state_q <= XFER;
               end else begin
                  gapCnt_q <= gapCnt_q + GW'(1);
               end
            end
            XFER: begin
               if (accept) begin
                  wdCnt_q <= '0;
                  if (selEop) begin
                     index_q <= '0;
                     if ((ARBIT_ALGORITHM == ALG_WRR) && (credit_q > CREDIT_ONE) && grantReqAny) begin
                        credit_q <= credit_q - CREDIT_ONE;
                     end else begin
                        grant_q <= '0;
                        state_q <= IDLE;
                        if (ARBIT_ALGORITHM != ALG_FIXED) begin
                           ptr_q <= ptr_d;
                        end
                     end
                  end else if (index_q != '1) begin
                     index_q <= index_q + INDX_WIDTH'(1);
                  end
               end else if (TIMEOUT_CYCLES > 0) begin
                  if (wdCnt_q == WD_LAST) begin
                     abort_q <= 1'b1;
                     grant_q <= '0;
                     state_q <= IDLE;
                     if (ARBIT_ALGORITHM != ALG_FIXED) begin
                        ptr_q <= ptr_d;
                     end
                  end else begin
                     wdCnt_q <= wdCnt_q + TW'(1);
                  end
               end
            end
            default: begin
               grant_q <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_util_pktarb_mux.sv
// Directed bench: dutA runs round robin with a 4-cycle watchdog, dutB weighted
// round robin; both share stimulus, the active test picks whose handshake advances sources.
module tb_util_pktarb_mux;

   localparam int N = 6;

   logic        clk_arbit = 1'b0;
   logic        rst_n;
   logic [N-1:0] din_valid, din_sop, din_eop;
   logic [63:0] din_data [N];
   logic [2:0]  din_empty [N];
   logic [1:0]  arbit_request [N];
   logic [3:0]  arbit_weight [N];
   logic        dout_ready;

   logic [N-1:0] aReady, aGrant, bReady, bGrant;
   logic [9:0]   aIndex, bIndex;
   logic         aAbort, aValid, aSop, aEop, bAbort, bValid, bSop, bEop;
   logic [63:0]  aData, bData;
   logic [2:0]   aEmpty, bEmpty;

   int   total = 0;
   int   bad = 0;
   logic srcEn [N];
   int   beatCnt [N];
   int   pktCnt [N];
   int   pktLen [N];
   logic useB;

   always #5 clk_arbit = ~clk_arbit;

   util_pktarb_mux #(
      .ARBIT_ALGORITHM (1),
      .MUX_SW_DELAY    (2),
      .TIMEOUT_CYCLES  (4)
   ) dutA (
      .clk_arbit (clk_arbit), .rst_n (rst_n),
      .din_valid (din_valid), .din_ready (aReady), .din_sop (din_sop), .din_eop (din_eop),
      .din_data (din_data), .din_empty (din_empty),
      .arbit_request (arbit_request), .arbit_weight (arbit_weight),
      .arbit_grant (aGrant), .arbit_index (aIndex), .arbit_abort (aAbort),
      .dout_valid (aValid), .dout_ready (dout_ready), .dout_sop (aSop), .dout_eop (aEop),
      .dout_data (aData), .dout_empty (aEmpty)
   );

   util_pktarb_mux #(
      .ARBIT_ALGORITHM (2),
      .MUX_SW_DELAY    (2),
      .TIMEOUT_CYCLES  (0)
   ) dutB (
      .clk_arbit (clk_arbit), .rst_n (rst_n),
      .din_valid (din_valid), .din_ready (bReady), .din_sop (din_sop), .din_eop (din_eop),
      .din_data (din_data), .din_empty (din_empty),
      .arbit_request (arbit_request), .arbit_weight (arbit_weight),
      .arbit_grant (bGrant), .arbit_index (bIndex), .arbit_abort (bAbort),
      .dout_valid (bValid), .dout_ready (dout_ready), .dout_sop (bSop), .dout_eop (bEop),
      .dout_data (bData), .dout_empty (bEmpty)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic driveSources();
      for (int c = 0; c < N; c++) begin
         din_valid[c] = srcEn[c];
         din_sop[c]   = srcEn[c] && (beatCnt[c] == 0);
         din_eop[c]   = srcEn[c] && (beatCnt[c] == pktLen[c] - 1);
         din_data[c]  = 64'hD000_0000 + 64'(c * 65536 + pktCnt[c] * 256 + beatCnt[c]);
         din_empty[c] = 3'(c);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      logic [N-1:0] acc;
      repeat (cycles) begin
         #1;
         acc = din_valid & (useB ? bReady : aReady);
         @(posedge clk_arbit);
         #1;
         for (int c = 0; c < N; c++) begin
            if (acc[c]) begin
               if (beatCnt[c] == pktLen[c] - 1) begin
                  beatCnt[c] = 0;
                  pktCnt[c]  = pktCnt[c] + 1;
               end else begin
                  beatCnt[c] = beatCnt[c] + 1;
               end
            end
         end
         driveSources();
         #1;
      end
   endtask

   task automatic startReset();
      rst_n      = 1'b0;
      dout_ready = 1'b1;
      for (int c = 0; c < N; c++) begin
         srcEn[c]         = 1'b0;
         beatCnt[c]       = 0;
         pktCnt[c]        = 0;
         pktLen[c]        = 3;
         arbit_request[c] = 2'b00;
         arbit_weight[c]  = 4'd1;
      end
      driveSources();
      #1;
   endtask

   task automatic releaseReset();
      driveSources();
      @(negedge clk_arbit);
      rst_n = 1'b1;
   endtask

   initial begin
      $display("[TB] start");

      // Round robin over ch0/ch2/ch5 with 3-beat packets
      useB = 1'b0;
      startReset();
      srcEn[0] = 1'b1; srcEn[2] = 1'b1; srcEn[5] = 1'b1;
      arbit_request[0] = 2'b01; arbit_request[2] = 2'b01; arbit_request[5] = 2'b01;
      driveSources();
      #1;
      checkOutput("rst_grant", 64'(aGrant), 64'd0);
      checkOutput("rst_index", 64'(aIndex), 64'd0);
      checkOutput("rst_ready", 64'(aReady), 64'd0);
      checkOutput("rst_valid", 64'(aValid), 64'd0);
      checkOutput("rst_abort", 64'(aAbort), 64'd0);
      checkOutput("rst_data", aData, 64'd0);
      releaseReset();
      applyStimulus(1);
      checkOutput("t1_grant_ch0", 64'(aGrant), 64'b000001);
      checkOutput("t1_gap_ready", 64'(aReady), 64'd0);
      applyStimulus(1);
      checkOutput("t1_gap_valid", 64'(aValid), 64'd0);
      applyStimulus(1);
      checkOutput("t1_ready_ch0", 64'(aReady), 64'b000001);
      checkOutput("t1_data_b0", aData, 64'hD000_0000);
      checkOutput("t1_sop_b0", 64'(aSop), 64'd1);
      checkOutput("t1_index_b0", 64'(aIndex), 64'd0);
      applyStimulus(1);
      checkOutput("t1_index_b1", 64'(aIndex), 64'd1);
      checkOutput("t1_data_b1", aData, 64'hD000_0001);
      checkOutput("t1_sop_b1", 64'(aSop), 64'd0);
      applyStimulus(1);
      checkOutput("t1_index_b2", 64'(aIndex), 64'd2);
      checkOutput("t1_eop_b2", 64'(aEop), 64'd1);
      applyStimulus(1);
      checkOutput("t1_release", 64'(aGrant), 64'd0);
      checkOutput("t1_index_clr", 64'(aIndex), 64'd0);
      applyStimulus(1);
      checkOutput("t1_grant_ch2", 64'(aGrant), 64'b000100);
      applyStimulus(2);
      checkOutput("t1_data_ch2", aData, 64'hD002_0000);
      checkOutput("t1_empty_ch2", 64'(aEmpty), 64'd2);
      applyStimulus(4);
      checkOutput("t1_grant_ch5", 64'(aGrant), 64'b100000);
      applyStimulus(2);
      checkOutput("t1_data_ch5", aData, 64'hD005_0000);
      applyStimulus(4);
      checkOutput("t1_grant_wrap", 64'(aGrant), 64'b000001);
      applyStimulus(2);
      checkOutput("t1_data_ch0_p1", aData, 64'hD000_0100);

      // Higher level arrives mid-packet: no preemption, then level 1 wins
      startReset();
      srcEn[0] = 1'b1; srcEn[1] = 1'b1; srcEn[3] = 1'b1;
      pktLen[3] = 2;
      arbit_request[1] = 2'b01;
      releaseReset();
      applyStimulus(1);
      checkOutput("t2_grant_ch1", 64'(aGrant), 64'b000010);
      applyStimulus(2);
      checkOutput("t2_data_ch1", aData, 64'hD001_0000);
      arbit_request[1] = 2'b00;
      arbit_request[0] = 2'b01;
      arbit_request[3] = 2'b10;
      applyStimulus(1);
      checkOutput("t2_no_preempt", 64'(aGrant), 64'b000010);
      checkOutput("t2_index", 64'(aIndex), 64'd1);
      applyStimulus(1);
      checkOutput("t2_eop_ch1", aData, 64'hD001_0002);
      checkOutput("t2_eop_flag", 64'(aEop), 64'd1);
      applyStimulus(1);
      checkOutput("t2_release", 64'(aGrant), 64'd0);
      applyStimulus(1);
      checkOutput("t2_grant_ch3", 64'(aGrant), 64'b001000);
      applyStimulus(2);
      checkOutput("t2_data_ch3", aData, 64'hD003_0000);

      // Weighted round robin: ch0 weight 3 bursts, ch1 weight 0 sends one packet
      useB = 1'b1;
      startReset();
      srcEn[0] = 1'b1; srcEn[1] = 1'b1;
      pktLen[0] = 2; pktLen[1] = 2;
      arbit_weight[0] = 4'd3; arbit_weight[1] = 4'd0;
      arbit_request[0] = 2'b01; arbit_request[1] = 2'b01;
      releaseReset();
      applyStimulus(1);
      checkOutput("t3_grant_ch0", 64'(bGrant), 64'b000001);
      applyStimulus(2);
      checkOutput("t3_data_p0", bData, 64'hD000_0000);
      applyStimulus(2);
      checkOutput("t3_burst_grant", 64'(bGrant), 64'b000001);
      checkOutput("t3_burst_valid", 64'(bValid), 64'd1);
      checkOutput("t3_data_p1", bData, 64'hD000_0100);
      checkOutput("t3_sop_p1", 64'(bSop), 64'd1);
      checkOutput("t3_index_p1", 64'(bIndex), 64'd0);
      applyStimulus(2);
      checkOutput("t3_data_p2", bData, 64'hD000_0200);
      applyStimulus(2);
      checkOutput("t3_release", 64'(bGrant), 64'd0);
      applyStimulus(1);
      checkOutput("t3_grant_ch1", 64'(bGrant), 64'b000010);
      applyStimulus(2);
      checkOutput("t3_data_ch1", bData, 64'hD001_0000);
      applyStimulus(2);
      checkOutput("t3_release_ch1", 64'(bGrant), 64'd0);
      applyStimulus(1);
      checkOutput("t3_grant_back", 64'(bGrant), 64'b000001);

      // Backpressure toggling, then watchdog abort, then async reset mid-packet
      useB = 1'b0;
      startReset();
      srcEn[2] = 1'b1; srcEn[4] = 1'b1;
      pktLen[2] = 4; pktLen[4] = 4;
      arbit_request[2] = 2'b01; arbit_request[4] = 2'b01;
      releaseReset();
      applyStimulus(3);
      checkOutput("t4_ready_hi", 64'(aReady), 64'b000100);
      checkOutput("t4_data_b0", aData, 64'hD002_0000);
      applyStimulus(1);
      checkOutput("t4_index1", 64'(aIndex), 64'd1);
      dout_ready = 1'b0;
      #1;
      checkOutput("t4_ready_lo", 64'(aReady), 64'd0);
      checkOutput("t4_valid_held", 64'(aValid), 64'd1);
      checkOutput("t4_data_b1", aData, 64'hD002_0001);
      applyStimulus(2);
      checkOutput("t4_index_stall", 64'(aIndex), 64'd1);
      checkOutput("t4_no_abort", 64'(aAbort), 64'd0);
      dout_ready = 1'b1;
      #1;
      checkOutput("t4_ready_back", 64'(aReady), 64'b000100);
      applyStimulus(1);
      checkOutput("t4_index2", 64'(aIndex), 64'd2);
      checkOutput("t4_data_b2", aData, 64'hD002_0002);
      dout_ready = 1'b0;
      applyStimulus(3);
      checkOutput("t4_pre_abort", 64'(aAbort), 64'd0);
      checkOutput("t4_pre_grant", 64'(aGrant), 64'b000100);
      applyStimulus(1);
      checkOutput("t4_abort", 64'(aAbort), 64'd1);
      checkOutput("t4_abort_grant", 64'(aGrant), 64'd0);
      dout_ready = 1'b1;
      applyStimulus(1);
      checkOutput("t4_abort_pulse", 64'(aAbort), 64'd0);
      checkOutput("t4_grant_ch4", 64'(aGrant), 64'b010000);
      applyStimulus(2);
      checkOutput("t4_data_ch4", aData, 64'hD004_0000);
      applyStimulus(1);
      checkOutput("t4_index_ch4", 64'(aIndex), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("t4_arst_grant", 64'(aGrant), 64'd0);
      checkOutput("t4_arst_valid", 64'(aValid), 64'd0);
      checkOutput("t4_arst_ready", 64'(aReady), 64'd0);
      checkOutput("t4_arst_index", 64'(aIndex), 64'd0);
      checkOutput("t4_arst_data", aData, 64'd0);
      startReset();
      srcEn[0] = 1'b1; srcEn[2] = 1'b1; srcEn[4] = 1'b1;
      arbit_request[0] = 2'b01; arbit_request[2] = 2'b01; arbit_request[4] = 2'b01;
      releaseReset();
      applyStimulus(1);
      checkOutput("t4_restart_ch0", 64'(aGrant), 64'b000001);

      // Request dropped during the switch gap cancels the grant
      startReset();
      srcEn[1] = 1'b1;
      arbit_request[1] = 2'b01;
      releaseReset();
      applyStimulus(1);
      checkOutput("t5_grant_ch1", 64'(aGrant), 64'b000010);
      arbit_request[1] = 2'b00;
      applyStimulus(1);
      checkOutput("t5_cancel", 64'(aGrant), 64'd0);
      checkOutput("t5_cancel_valid", 64'(aValid), 64'd0);
      applyStimulus(3);
      checkOutput("t5_idle_grant", 64'(aGrant), 64'd0);
      checkOutput("t5_idle_ready", 64'(aReady), 64'd0);
      arbit_request[1] = 2'b01;
      applyStimulus(1);
      checkOutput("t5_regrant", 64'(aGrant), 64'b000010);
      applyStimulus(2);
      checkOutput("t5_first_beat", aData, 64'hD001_0000);
      checkOutput("t5_first_sop", 64'(aSop), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/util_pktarb_mux.md
Name: util_pktarb_mux

Overview:
Parametrised packet multiplexer with multilevel request arbitration and valid/ready backpressure on both sides. Within a level, channels are arbitrated by fixed priority, round robin or weighted round robin. A grant is held for a whole packet, or for a burst of packets under weighted round robin. The block sits between per-channel packet sources (FACC 5G pack path) and a single downstream stream sink; it is the backpressure-capable successor to the plain arbitrate mux.

Parameters:
DATA_WIDTH, 64, data bit width
EMPT_WIDTH, BIT_WIDTH(DATA_WIDTH/8-1), empty field width; port width is max(EMPT_WIDTH,1)
CHANNEL_QTY, 6, input channels, min 1
ARBIT_LEVEL, 2, request levels, min 1; level ARBIT_LEVEL-1 is highest
ARBIT_ALGORITHM, 1, 0 fixed priority (lower channel wins), 1 round robin, 2 weighted round robin
WEIGHT_WIDTH, 4, per-channel weight width
MUX_SW_DELAY, 2, gap cycles between grant and first transferable beat, min 0
TIMEOUT_CYCLES, 0, stall watchdog limit in cycles; 0 disables
INDX_WIDTH, 10, beat index width

Ports:
clk_arbit  in  1  clock, posedge
rst_n  in  1  reset, asynchronous, active-low
din_valid  in  CHANNEL_QTY  per-channel beat valid
din_ready  out  CHANNEL_QTY  per-channel beat accept
din_sop  in  CHANNEL_QTY  start of packet
din_eop  in  CHANNEL_QTY  end of packet
din_data  in  DATA_WIDTH x CHANNEL_QTY (unpacked)  data
din_empty  in  EMPT x CHANNEL_QTY (unpacked)  empty bytes
arbit_request  in  ARBIT_LEVEL x CHANNEL_QTY (unpacked)  per-channel level requests
arbit_weight  in  WEIGHT_WIDTH x CHANNEL_QTY (unpacked)  packets per burst (algorithm 2); 0 is treated as 1
arbit_grant  out  CHANNEL_QTY  one-hot grant, registered
arbit_index  out  INDX_WIDTH  beats accepted in current packet
arbit_abort  out  1  one-cycle pulse on watchdog release
dout_valid  out  1  output valid
dout_ready  in  1  downstream accept
dout_sop, dout_eop  out  1  gated by dout_valid
dout_data  out  DATA_WIDTH  muxed data
dout_empty  out  EMPT  muxed empty

Behaviour:
- Reset: state IDLE; arbit_grant, arbit_index, arbit_abort, round-robin pointer, credit and gap/watchdog counters all 0. din_ready and dout_* read 0 because grant is 0.
- States: IDLE, GAP, XFER.
- Level selection: the highest level n with any arbit_request[*][n] set is active. Winner is picked among channels requesting at level n only.
- Alg 0: lowest channel index wins.
- Alg 1/2: first requester at or after ptr, wrapping modulo CHANNEL_QTY.
- IDLE, any request: register the winner one-hot into arbit_grant and load credit = max(weight,1). Go to GAP if MUX_SW_DELAY>0, else XFER. First IDLE->grant costs one cycle.
- GAP: count MUX_SW_DELAY cycles with din_ready=0, then go to XFER. If the granted channel's request drops to all-zero during GAP, cancel: clear grant, go to IDLE, ptr unchanged.
- XFER: dout_* = granted channel's signals; din_ready[g] = dout_ready, others 0. Combinational path, zero latency. A beat is accepted when din_valid[g] & dout_ready.
- arbit_index: cleared on entry to XFER and after each accepted eop; increments per accepted beat; saturates at all-ones.
- Accepted eop beat, alg 2: if credit>1 and the granted channel still has any request, decrement credit and stay in XFER with no gap. Otherwise release.
- Release: clear grant, go to IDLE. For alg 1/2, ptr = (g+1) mod CHANNEL_QTY. Request drop during XFER never releases before eop.
- Watchdog (TIMEOUT_CYCLES>0): counts consecutive XFER cycles with no accepted beat. When the count reaches TIMEOUT_CYCLES: pulse arbit_abort, release as above. An accepted beat in the same cycle wins: counter clears, no abort.
- Higher-level requests never preempt an active grant.
- CHANNEL_QTY=1: ptr fixed at 0; otherwise identical behaviour.

Decomposition:
- Package util_pktarb_pkg holds:
  - state enum typedef (IDLE/GAP/XFER);
  - algorithm constants ALG_FIXED/ALG_RR/ALG_WRR;
  - BIT_WIDTH function.
- Sub-module util_pktarb_pick: combinational masked priority picker (request vector, pointer, algorithm -> one-hot winner). Instantiated once on the selected level's request vector.

Test Plan:
- Alg 1, ch0/ch2/ch5 continuously requesting level 0, 3-beat packets, dout_ready=1 -> grant order 0,2,5,0; MUX_SW_DELAY=2 gap before each first beat; arbit_index 0,1,2.
- Ch1 holding grant at level 0 while ch3 raises level 1 mid-packet -> ch1 finishes its eop, then ch3 granted ahead of the level-0 ch0.
- Alg 2, weight ch0=3, ch1=0 -> ch0 sends 3 back-to-back packets with no gaps, then ch1 sends 1 packet.
- dout_ready toggling 1,0,0,1 during a packet -> din_ready mirrors it, no beat lost or duplicated; TIMEOUT_CYCLES=4 with ready held 0 -> arbit_abort on the 4th stall cycle, then the next channel is granted.
- Request dropped during GAP -> grant clears and no beat is transferred; rst_n asserted mid-packet -> all outputs 0 asynchronously; after release, arbitration restarts from ch0.
